// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: state encoding and opcode constants shared by the ALU arbiter and its clients
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals; master is the client/ALU side, slave is the arbiter
interface alu_arbiter_if #(parameter int WIDTH = 8);
  logic req0_valid;
  logic req0_ready;
  logic [WIDTH-1:0] req0_operandA;
  logic [WIDTH-1:0] req0_operandB;
  logic req0_opcode;
  logic req1_valid;
  logic req1_ready;
  logic [WIDTH-1:0] req1_operandA;
  logic [WIDTH-1:0] req1_operandB;
  logic req1_opcode;
  logic [WIDTH-1:0] alu_operandA;
  logic [WIDTH-1:0] alu_operandB;
  logic alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic busy;
  modport master (
    output req0_valid, req0_operandA, req0_operandB, req0_opcode,
    output req1_valid, req1_operandA, req1_operandB, req1_opcode,
    output alu_result, rsp_ready,
    input req0_ready, req1_ready, alu_operandA, alu_operandB, alu_opcode,
    input rsp_valid, rsp_id, rsp_data, busy
  );
  modport slave (
    input req0_valid, req0_operandA, req0_operandB, req0_opcode,
    input req1_valid, req1_operandA, req1_operandB, req1_opcode,
    input alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_operandA, alu_operandB, alu_opcode,
    output rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; ptr picks the winner only when both request
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       idx
);
  always_comb begin
    idx = &valid ? ptr : valid[1];
    grant = |valid ? (idx ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer that issues one add/sub at a time to a shared ALU
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALU_LATENCY = 1
) (
  input logic clock,
  input logic reset_n,
  alu_arbiter_if.slave bus
);
  localparam int CW = ALU_LATENCY > 1 ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LATENCY - 1);
  state_t state, state_nx;
  logic rr_ptr, idx, accept, rsp_id;
  logic [1:0] grant;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] op_a, op_b, rsp_data;
  logic op_c;
  rr_arbiter2 u_rr (
    .valid({bus.req1_valid, bus.req0_valid}),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(idx)
  );
  assign accept = state == IDLE && |grant;
  always_ff @(posedge clock)
    state <= !reset_n ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
               state == EXEC ? (cnt == '0 ? RESP : EXEC) :
               state == RESP ? (bus.rsp_ready ? IDLE : RESP) : IDLE;
  always_comb begin
    bus.req0_ready = state == IDLE && grant[0];
    bus.req1_ready = state == IDLE && grant[1];
    bus.rsp_valid = state == RESP;
    bus.busy = state != IDLE;
  end
  // operands stay parked on the ALU outside EXEC to avoid needless toggling
  always_ff @(posedge clock)
    if (!reset_n) begin
      rr_ptr <= 1'b0;
      cnt <= '0;
      op_a <= '0;
      op_b <= '0;
      op_c <= OP_ADD;
      rsp_id <= 1'b0;
      rsp_data <= '0;
    end else if (accept) begin
      op_a <= idx ? bus.req1_operandA : bus.req0_operandA;
      op_b <= idx ? bus.req1_operandB : bus.req0_operandB;
      op_c <= idx ? bus.req1_opcode : bus.req0_opcode;
      rsp_id <= idx;
      rr_ptr <= ~idx;
      cnt <= CNT_LOAD;
    end else if (state == EXEC) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) rsp_data <= bus.alu_result;
    end
  assign bus.alu_operandA = op_a;
  assign bus.alu_operandB = op_b;
  assign bus.alu_opcode = op_c;
  assign bus.rsp_id = rsp_id;
  assign bus.rsp_data = rsp_data;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives two arbiters (latency 1 and 3) against a transaction-level round-robin model
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  logic v0 = 1'b0, v1 = 1'b0, rr = 1'b0, sel = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic o0 = 1'b0, o1 = 1'b0;
  bit [1:0] m_ptr = 2'b00;
  int total = 0, bad = 0;
  alu_arbiter_if #(.WIDTH(8)) i1 ();
  alu_arbiter_if #(.WIDTH(8)) i3 ();
  assign i1.req0_valid = v0 && !sel;
  assign i1.req1_valid = v1 && !sel;
  assign i1.rsp_ready = rr && !sel;
  assign i3.req0_valid = v0 && sel;
  assign i3.req1_valid = v1 && sel;
  assign i3.rsp_ready = rr && sel;
  assign i1.req0_operandA = a0;
  assign i1.req0_operandB = b0;
  assign i1.req0_opcode = o0;
  assign i1.req1_operandA = a1;
  assign i1.req1_operandB = b1;
  assign i1.req1_opcode = o1;
  assign i3.req0_operandA = a0;
  assign i3.req0_operandB = b0;
  assign i3.req0_opcode = o0;
  assign i3.req1_operandA = a1;
  assign i3.req1_operandB = b1;
  assign i3.req1_opcode = o1;
  assign i1.alu_result = i1.alu_opcode == OP_SUB ? i1.alu_operandA - i1.alu_operandB : i1.alu_operandA + i1.alu_operandB;
  assign i3.alu_result = i3.alu_opcode == OP_SUB ? i3.alu_operandA - i3.alu_operandB : i3.alu_operandA + i3.alu_operandB;
  alu_arbiter #(.WIDTH(8), .ALU_LATENCY(1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(i1));
  alu_arbiter #(.WIDTH(8), .ALU_LATENCY(3)) dut3 (.clock(clock), .reset_n(reset_n), .bus(i3));
  logic rdy0, rdy1, rv, rid, busy, ao;
  logic [7:0] rdata, aa, ab;
  assign rdy0 = sel ? i3.req0_ready : i1.req0_ready;
  assign rdy1 = sel ? i3.req1_ready : i1.req1_ready;
  assign rv = sel ? i3.rsp_valid : i1.rsp_valid;
  assign rid = sel ? i3.rsp_id : i1.rsp_id;
  assign busy = sel ? i3.busy : i1.busy;
  assign rdata = sel ? i3.rsp_data : i1.rsp_data;
  assign aa = sel ? i3.alu_operandA : i1.alu_operandA;
  assign ab = sel ? i3.alu_operandB : i1.alu_operandB;
  assign ao = sel ? i3.alu_opcode : i1.alu_opcode;

  task automatic do_reset();
    v0 = 1'b0;
    v1 = 1'b0;
    rr = 1'b0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    m_ptr = 2'b00;
  endtask

  // one full transaction: accept, execute, optional backpressure, response handshake
  task automatic do_op(input bit pv0, input bit pv1, input int hold, input string nm);
    int g, lat, n;
    logic [7:0] ea, eb, ed;
    logic eo;
    lat = sel ? 3 : 1;
    g = (pv0 && pv1) ? int'(m_ptr[sel]) : (pv1 ? 1 : 0);
    ea = g == 1 ? a1 : a0;
    eb = g == 1 ? b1 : b0;
    eo = g == 1 ? o1 : o0;
    ed = eo ? ea - eb : ea + eb;
    v0 = pv0;
    v1 = pv1;
    @(negedge clock);
    total++;
    if ({rdy1, rdy0} !== (g == 1 ? 2'b10 : 2'b01) || rv !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s grant: ready=%b rsp_valid=%b busy=%b, expected ready=%b idle", nm, {rdy1, rdy0}, rv, busy, g == 1 ? 2'b10 : 2'b01);
    end
    @(posedge clock); #1;
    @(negedge clock);
    n = 0;
    while (rv !== 1'b1 && n < 10) begin
      total++;
      if ({aa, ab, ao} !== {ea, eb, eo} || {rdy1, rdy0} !== 2'b00 || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s exec: alu=%h/%h/%b ready=%b busy=%b, expected alu=%h/%h/%b ready=00 busy=1", nm, aa, ab, ao, {rdy1, rdy0}, busy, ea, eb, eo);
      end
      @(negedge clock);
      n++;
    end
    total++;
    if (n != lat || rid !== g[0] || rdata !== ed) begin
      bad++;
      $display("FAIL %s response: latency=%0d id=%b data=%h, expected latency=%0d id=%b data=%h", nm, n, rid, rdata, lat, g[0], ed);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      total++;
      if (rv !== 1'b1 || rid !== g[0] || rdata !== ed || {rdy1, rdy0} !== 2'b00 || busy !== 1'b1 || {aa, ab, ao} !== {ea, eb, eo}) begin
        bad++;
        $display("FAIL %s backpressure: valid=%b id=%b data=%h ready=%b busy=%b alu=%h/%h, expected valid=1 id=%b data=%h ready=00 busy=1 alu=%h/%h", nm, rv, rid, rdata, {rdy1, rdy0}, busy, aa, ab, g[0], ed, ea, eb);
      end
    end
    @(posedge clock); #1;
    rr = 1'b1;
    @(negedge clock);
    total++;
    if (rv !== 1'b1 || rdata !== ed || {rdy1, rdy0} !== 2'b00) begin
      bad++;
      $display("FAIL %s handshake: valid=%b data=%h ready=%b, expected valid=1 data=%h ready=00", nm, rv, rdata, {rdy1, rdy0}, ed);
    end
    @(posedge clock); #1;
    rr = 1'b0;
    m_ptr[sel] = ~g[0];
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    total++;
    if ({i1.alu_operandA, i1.alu_operandB, i1.alu_opcode, i1.rsp_valid, i1.rsp_id, i1.rsp_data, i1.req0_ready, i1.req1_ready, i1.busy} !== 31'd0) begin
      bad++;
      $display("FAIL reset lat1: alu=%h/%h/%b rsp=%b/%b/%h ready=%b%b busy=%b, expected all zero", i1.alu_operandA, i1.alu_operandB, i1.alu_opcode, i1.rsp_valid, i1.rsp_id, i1.rsp_data, i1.req1_ready, i1.req0_ready, i1.busy);
    end
    total++;
    if ({i3.alu_operandA, i3.alu_operandB, i3.alu_opcode, i3.rsp_valid, i3.rsp_id, i3.rsp_data, i3.req0_ready, i3.req1_ready, i3.busy} !== 31'd0) begin
      bad++;
      $display("FAIL reset lat3: alu=%h/%h/%b rsp=%b/%b/%h ready=%b%b busy=%b, expected all zero", i3.alu_operandA, i3.alu_operandB, i3.alu_opcode, i3.rsp_valid, i3.rsp_id, i3.rsp_data, i3.req1_ready, i3.req0_ready, i3.busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single_add();
    sel = 1'b0;
    a0 = 8'd5; b0 = 8'd3; o0 = OP_ADD;
    do_op(1'b1, 1'b0, 0, "single_add");
  endtask

  task automatic test_contention();
    do_reset();
    sel = 1'b0;
    a0 = 8'd20; b0 = 8'd7; o0 = OP_SUB;
    a1 = 8'd9; b1 = 8'd9; o1 = OP_ADD;
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b1, 0, "contention");
  endtask

  task automatic test_back_to_back();
    bit l;
    sel = 1'b0;
    a0 = 8'd100; b0 = 8'd27; o0 = OP_ADD;
    a1 = 8'd64; b1 = 8'd1; o1 = OP_SUB;
    do_op(1'b1, 1'b1, 5, "backpressure");
    l = m_ptr[0];
    do_op(l == 1'b0, l == 1'b1, 0, "after_backpressure");
  endtask

  task automatic test_wrap();
    sel = 1'b0;
    a1 = 8'd2; b1 = 8'd5; o1 = OP_SUB;
    do_op(1'b0, 1'b1, 0, "wrap_sub");
    a0 = 8'd250; b0 = 8'd10; o0 = OP_ADD;
    do_op(1'b1, 1'b0, 1, "wrap_add");
  endtask

  task automatic test_latency();
    sel = 1'b1;
    a0 = 8'd33; b0 = 8'd44; o0 = OP_ADD;
    a1 = 8'd7; b1 = 8'd200; o1 = OP_SUB;
    do_op(1'b1, 1'b0, 2, "lat3_req0");
    do_op(1'b1, 1'b1, 0, "lat3_both");
    do_op(1'b1, 1'b1, 1, "lat3_both2");
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    sel = 1'b1;
    a0 = 8'd77; b0 = 8'd11; o0 = OP_SUB;
    a1 = 8'd1; b1 = 8'd2; o1 = OP_ADD;
    v0 = 1'b1;
    @(negedge clock);
    total++;
    if (rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid accept: req0_ready=%b, expected 1", rdy0);
    end
    @(posedge clock); #1;
    v0 = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    m_ptr = 2'b00;
    @(negedge clock);
    total++;
    if ({aa, ab, ao, rv, rid, rdata, rdy0, rdy1, busy} !== 31'd0) begin
      bad++;
      $display("FAIL reset_mid outputs: alu=%h/%h/%b rsp=%b/%b/%h ready=%b%b busy=%b, expected all zero", aa, ab, ao, rv, rid, rdata, rdy1, rdy0, busy);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      total++;
      if (rv !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid lost: rsp_valid=%b busy=%b, expected 0 0", rv, busy);
      end
    end
    @(posedge clock); #1;
    do_op(1'b1, 1'b1, 0, "reset_mid_rr");
    sel = 1'b0;
  endtask

  task automatic test_random();
    bit p0, p1;
    for (int i = 0; i < 30; i++) begin
      sel = (i % 6) == 5;
      a0 = 8'($urandom); b0 = 8'($urandom); o0 = 1'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); o1 = 1'($urandom);
      p0 = 1'($urandom);
      p1 = p0 ? 1'($urandom) : 1'b1;
      do_op(p0, p1, int'($urandom_range(0, 3)), "random");
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_back_to_back();
    test_wrap();
    test_latency();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
